// File: rtl/lsu_mem_unit_if.sv
// Bundle of the EX-side request, memory request/response and WB-side result channels
// seen by the load/store unit.
interface lsu_mem_unit_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_lsu_op;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [4:0]        in_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [STRB_W-1:0] mem_req_wstrb;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [4:0]        out_rd;
  logic              out_we;
  logic              out_err;

  // The load/store unit itself.
  modport slave (
    input  in_valid, in_lsu_op, in_addr, in_wdata, in_rd,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  out_ready,
    output in_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output out_valid, out_result, out_rd, out_we, out_err
  );

  // The surrounding pipeline and memory system.
  modport master (
    output in_valid, in_lsu_op, in_addr, in_wdata, in_rd,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output out_ready,
    input  in_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  out_valid, out_result, out_rd, out_we, out_err
  );
endinterface

// File: rtl/lsu_mem_unit.sv
// RV64I load/store unit: one access in flight, store lane replication/strobes,
// load lane extraction with sign/zero extension, result handed to WB.
module lsu_mem_unit #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_unit_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned SIZE_W = 4;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t state_q, state_d;

  // Captured access
  logic              we_q;
  logic [SIZE_W-1:0] size_q;
  logic              uns_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [4:0]        rd_q;
  logic              err_q;
  logic [DATA_W-1:0] result_q;
  logic              rwe_q;

  // Request-side decode
  logic [SIZE_W-1:0] in_size;
  logic [OFF_W-1:0]  in_off;
  logic              illegal;
  logic              misalign;
  logic              in_err;
  logic [DATA_W-1:0] st_data;
  logic [STRB_W-1:0] st_strb;

  // Response-side extraction
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_ext;
  logic              ld_sign;

  logic accept;
  logic resp_hit;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign resp_hit = (state_q == RESP) && bus.mem_resp_valid;

  // Legality, alignment and store lane formatting of the incoming op
  always_comb begin
    in_size  = bus.in_lsu_op[4:1];
    in_off   = bus.in_addr[OFF_W-1:0];
    illegal  = !bus.in_lsu_op[6] || !$onehot(in_size);
    misalign = (in_size[1] && in_off[0])
            || (in_size[2] && (in_off[1:0] != 2'b00))
            || (in_size[3] && (in_off != 3'b000));
    in_err   = illegal || misalign;
    st_data  = '0;
    st_strb  = '0;
    if (bus.in_lsu_op[5]) begin
      case (in_size)
        4'b0001: begin
          st_data = {8{bus.in_wdata[7:0]}};
          st_strb = 8'h01 << in_off;
        end
        4'b0010: begin
          st_data = {4{bus.in_wdata[15:0]}};
          st_strb = 8'h03 << in_off;
        end
        4'b0100: begin
          st_data = {2{bus.in_wdata[31:0]}};
          st_strb = 8'h0F << in_off;
        end
        4'b1000: begin
          st_data = bus.in_wdata;
          st_strb = 8'hFF;
        end
        default: begin
          st_data = '0;
          st_strb = '0;
        end
      endcase
    end
  end

  // Load lane extraction and extension; dword ignores the unsigned bit
  always_comb begin
    ld_shift = bus.mem_resp_rdata >> {off_q, 3'b000};
    ld_sign  = !uns_q;
    ld_ext   = ld_shift;
    case (size_q)
      4'b0001: ld_ext = {{56{ld_sign && ld_shift[7]}},  ld_shift[7:0]};
      4'b0010: ld_ext = {{48{ld_sign && ld_shift[15]}}, ld_shift[15:0]};
      4'b0100: ld_ext = {{32{ld_sign && ld_shift[31]}}, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)       state_d = in_err ? DONE : REQ;
      REQ:     if (bus.mem_req_ready)  state_d = RESP;
      RESP:    if (bus.mem_resp_valid) state_d = DONE;
      DONE:    if (bus.out_ready)      state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // Access capture and result formation
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      rwe_q    <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= bus.in_lsu_op[5];
        size_q   <= in_size;
        uns_q    <= bus.in_lsu_op[0];
        off_q    <= in_off;
        addr_q   <= {bus.in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        wdata_q  <= st_data;
        wstrb_q  <= st_strb;
        rd_q     <= bus.in_rd;
        err_q    <= in_err;
        result_q <= '0;
        rwe_q    <= 1'b0;
      end
      if (resp_hit) begin
        result_q <= we_q ? '0 : ld_ext;
        rwe_q    <= !we_q;
      end
    end
  end

  // Outputs are pure decodes of the registered state and captured access
  always_comb begin
    bus.in_ready      = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    bus.mem_req_wstrb = '0;
    bus.out_valid     = 1'b0;
    bus.out_result    = '0;
    bus.out_rd        = '0;
    bus.out_we        = 1'b0;
    bus.out_err       = 1'b0;
    case (state_q)
      IDLE: bus.in_ready = 1'b1;
      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = we_q;
        bus.mem_req_addr  = addr_q;
        bus.mem_req_wdata = wdata_q;
        bus.mem_req_wstrb = wstrb_q;
      end
      DONE: begin
        bus.out_valid  = 1'b1;
        bus.out_result = result_q;
        bus.out_rd     = rd_q;
        bus.out_we     = rwe_q;
        bus.out_err    = err_q;
      end
      default: ;
    endcase
  end
endmodule
